imm_extend_pipe: RTL
====================

# imm_extend_pipe

Parametrised, pipelined immediate extender for the datapath's decode/execute boundary. It takes an IN_W-bit immediate and a mode, and produces an OUT_W-bit operand: sign-extended, zero-extended or upper-placed. Transfer uses a valid/ready handshake behind a two-entry skid buffer, so backpressure from the execute stage never drops or duplicates an immediate. It supersedes the fixed 8-to-16 registered sign extender.

## Interface
- IN_W, 8, immediate input width; legal range 1..OUT_W.
- OUT_W, 16, extended output width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_mode are presented.
- in_ready  output  1  the block can accept this cycle.
- in_data  input  IN_W  raw immediate.
- in_mode  input  2  00 sign-extend, 01 zero-extend, 10 upper-place, 11 reserved.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  the consumer accepts this cycle.
- out_data  output  OUT_W  extended immediate.
- out_err  output  1  result came from a reserved or disabled mode; qualified by out_valid.

## Operation
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Extension rules:
  - Sign: out_data = {(OUT_W-IN_W){in_data[IN_W-1]}, in_data}.
  - Zero: out_data = {(OUT_W-IN_W){1'b0}, in_data}.
  - Upper: out_data = {in_data, (OUT_W-IN_W){1'b0}}.
  - IN_W == OUT_W: every mode passes in_data through unchanged.
- Mode 11: zero-extended result with out_err=1.
- Storage is a main register (M) plus a skid register (S). States by occupancy:
  - EMPTY (M empty).
  - ONE (M full, S empty).
  - TWO (both full).
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept without drain -> TWO. Drain without accept -> EMPTY. Accept and drain together -> ONE, with M replaced by the new item.
  - TWO: drain -> ONE, with S moving to M. in_ready=0, so no accept is possible.
- Ordering: results are output strictly in acceptance order.
- in_ready = !S_valid, taken from a register with no combinational path from out_ready. This allows full throughput of one per cycle with out_ready held high.

## Timing
- Reset (rst low, asynchronous):
  - out_valid=0, out_data=0, out_err=0.
  - S empty, so in_ready=1.
  - Takes effect immediately regardless of clk.
- Reset mid-operation discards both entries. No partial result appears after release.
- Latency: an item accepted at edge N is on out_data with out_valid=1 after edge N (1 cycle).
- out_data and out_err hold stable while out_valid && !out_ready.
- in_ready falls the cycle after the accept that fills S. It rises the cycle after the drain that empties S.
- Simultaneous accept and drain in ONE: no bubble, and out_valid stays high.

## Configuration
- Macro: IMM_EXTEND_UPPER_EN.
- Defined: mode 10 performs upper-place with out_err=0.
- Undefined: upper-place logic is absent. Mode 10 behaves like mode 11 (zero-extend, out_err=1).
- Sign and zero modes are unaffected either way.

## Structure
- Package imm_extend_pkg holds:
  - the 2-bit mode constants MODE_SIGN, MODE_ZERO, MODE_UPPER, MODE_RSVD;
  - an extend function (data, mode) -> {err, result}, parametrised by widths.
- Sub-module skid_reg: generic two-entry valid/ready buffer, parametrised by payload width. Its payload is {out_err, out_data}.
- The top level is the extension logic feeding skid_reg. Extension happens before storage, so stored entries are already final.

## Test plan
- Reset, then sign mode with IN_W=8, OUT_W=16, out_ready=1: 0x77 -> 0x0077; 0xF2 -> 0xFFF2; one result per cycle, latency 1.
- Zero and upper modes on 0xF2 -> 0x00F2 and 0xF200. Mode 11 -> 0x00F2 with out_err=1. Without IMM_EXTEND_UPPER_EN, mode 10 -> 0x00F2 with out_err=1.
- Backpressure: with out_ready=0, send 0x12 then 0x20. in_ready drops after the second accept, and a third item is held. Then raise out_ready: order is 0x0012, 0x0020, third item, with no loss or duplicate.
- Simultaneous accept/drain in ONE for 10 cycles at full rate: out_valid stays 1, in_ready stays 1, data matches the input sequence.
- Assert rst asynchronously (mid-cycle) while in TWO: out_valid drops immediately and in_ready=1. After release, the first output is the first new input.
- IN_W=OUT_W=16 build: all modes pass 0x8001 through unchanged.

Source files
------------

// File: rtl/imm_extend_pkg.sv
// Shared types for the immediate extender: mode codes, skid buffer states and the width-generic extend function.
// Mode 10 performs upper-place only when IMM_EXTEND_UPPER_EN is defined; otherwise it is reported as an error like mode 11.
package imm_extend_pkg;

  localparam logic [1:0] MODE_SIGN  = 2'b00;
  localparam logic [1:0] MODE_ZERO  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  // Widest operand the extend function handles; OUT_W must stay below this.
  localparam int EXT_MAX_W = 64;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  // data carries the raw immediate in its low in_w bits, with zeros above.
  // Returns {err, result}; only the low out_w bits of result are meaningful.
  function automatic logic [EXT_MAX_W:0] extend(
    input logic [EXT_MAX_W-1:0] data,
    input logic [1:0]           mode,
    input int                   in_w,
    input int                   out_w
  );
    logic [EXT_MAX_W-1:0] res;
    logic                 err;
    logic                 msb;
    res = '0;
    err = 1'b0;
    msb = 1'b0;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i == in_w - 1) msb = data[i];
    end
    case (mode)
      MODE_SIGN: begin
        for (int i = 0; i < EXT_MAX_W; i++) begin
          if (i < in_w)       res[i] = data[i];
          else if (i < out_w) res[i] = msb;
          else                res[i] = 1'b0;
        end
      end
      MODE_ZERO: begin
        res = data;
      end
      MODE_UPPER: begin
`ifdef IMM_EXTEND_UPPER_EN
        res = data << (out_w - in_w);
`else
        res = data;
        err = 1'b1;
`endif
      end
      default: begin
        res = data;
        err = 1'b1;
      end
    endcase
    return {err, res};
  endfunction

endpackage

// File: rtl/skid_reg.sv
// Two-entry valid/ready buffer (main + skid register); 1-cycle latency, full rate with out_ready high.
// Backpressure: in_ready is a flop that drops once the skid entry fills, so no combinational path from out_ready.
module skid_reg
  import imm_extend_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state;
  skid_state_t  state_nxt;
  logic [W-1:0] m_dat;
  logic [W-1:0] s_dat;
  logic         rdy_q;
  logic         push;
  logic         pop;
  logic         m_ld;
  logic         m_from_s;
  logic         s_ld;

  assign push = in_valid && rdy_q;
  assign pop  = (state != SKID_EMPTY) && out_ready;

  always_comb begin
    state_nxt = state;
    m_ld      = 1'b0;
    m_from_s  = 1'b0;
    s_ld      = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (push) begin
          m_ld      = 1'b1;
          state_nxt = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          m_ld = 1'b1;
        end else if (push) begin
          s_ld      = 1'b1;
          state_nxt = SKID_TWO;
        end else if (pop) begin
          state_nxt = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        // in_ready is low here, so only a drain can move the state.
        if (pop) begin
          m_ld      = 1'b1;
          m_from_s  = 1'b1;
          state_nxt = SKID_ONE;
        end
      end
      default: begin
        state_nxt = SKID_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SKID_EMPTY;
      m_dat <= '0;
      s_dat <= '0;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != SKID_TWO);
      if (m_ld) m_dat <= m_from_s ? s_dat : in_data;
      if (s_ld) s_dat <= in_data;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = m_dat;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: extends before storage into a skid_reg, 1-cycle latency, no loss under backpressure.
// IMM_EXTEND_UPPER_EN enables upper-place for mode 10; without it mode 10 yields zero-extend with out_err set.
module imm_extend_pipe
  import imm_extend_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  logic [EXT_MAX_W-1:0]       data_wide;
  logic                       ext_err;
  logic [EXT_MAX_W-OUT_W-1:0] ext_unused;
  logic [OUT_W-1:0]           ext_res;
  logic [OUT_W:0]             pay_out;

  always_comb begin
    data_wide             = '0;
    data_wide[IN_W-1:0]   = in_data;
  end

  assign {ext_err, ext_unused, ext_res} = extend(data_wide, in_mode, IN_W, OUT_W);

  skid_reg #(
    .W(OUT_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({ext_err, ext_res}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pay_out)
  );

  assign {out_err, out_data} = pay_out;

endmodule
